card_list_manager: RTL and testbench
====================================

# card_list_manager

Parametrised linked-list card store: several independent card lists (deck, hands, discard) held in one on-chip RAM, with a hardware free-list allocator. Supports inserting a card at the head of any list and removing the nth card of any list, returning its value and suit. Sits between the game-control FSM and card memory; replaces ad-hoc per-operation store/remove logic with a single command/handshake engine.

## Interface

- ADDR_W, 10, RAM address width; depth = 2^ADDR_W entries; address 0 reserved as NULL, so capacity is 2^ADDR_W − 1 cards
- VALUE_W, 4, card value width
- SUIT_W, 2, card suit width
- NUM_LISTS, 4, number of independent lists (≥1)
- LIST_W, 2, width of list select (≥ ceil(log2(NUM_LISTS)), minimum 1)

- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  command request; accepted when start && ready at a rising edge
- op  in  1  0 = INSERT, 1 = REMOVE_NTH
- list_sel  in  LIST_W  target list
- in_value  in  VALUE_W  card value (INSERT)
- in_suit  in  SUIT_W  card suit (INSERT)
- n  in  ADDR_W  0-based position from head (REMOVE_NTH)
- ready  out  1  engine idle, may accept a command
- done  out  1  one-cycle pulse: command finished
- err  out  1  valid with done: command rejected, no state changed
- out_value  out  VALUE_W  removed card value, valid from done until next accept
- out_suit  out  SUIT_W  removed card suit, same validity
- count  out  ADDR_W  number of cards in list list_sel (combinational from count registers)
- free_count  out  ADDR_W  free entries remaining

## Operation

- RAM entry: {suit, value, next[ADDR_W-1:0]}; synchronous single-port RAM, read data available the cycle after address is presented; write on the same edge as wren.
- Per list: head pointer (NULL = empty) and count register. Free list: free_head pointer plus free_count.
- States: INIT, IDLE, INS_RD, INS_WR, REM_RD, REM_CHK, REM_LINK, REM_FREE, DONE.
- INIT: sweeps addresses 1..DEPTH−1, writing next = addr+1 (last entry next = NULL); free_head = 1; then IDLE. ready = 1 only in IDLE.
- Accept: all inputs captured; later input changes have no effect. start while ready = 0 is ignored (not queued).
- INSERT: if free_count == 0 → DONE with err. Else INS_RD reads free_head; INS_WR writes {in_suit, in_value, head[list]} at old free_head, head[list] ← old free_head, free_head ← read next, count+1, free_count−1.
- REMOVE_NTH: if n ≥ count[list] → DONE with err. Else prev = NULL, cur = head, k = 0; loop REM_RD (issue cur) → REM_CHK (capture entry); if k < n: prev = cur, save prev entry, cur = next, k+1, back to REM_RD. At k == n: REM_LINK — if prev == NULL head[list] ← cur.next, else write prev entry with next = cur.next. REM_FREE writes cur with next = free_head; free_head ← cur; count−1, free_count+1; out_value/out_suit ← cur data.
- DONE: done = 1 for one cycle, then IDLE.
- Lists never share entries; total of all counts + free_count = DEPTH−1 at all times in IDLE.

## Timing

- Reset values: ready 0, done 0, err 0, out_value 0, out_suit 0, all heads NULL, all counts 0, free_count = DEPTH−1, free_head 1.
- INIT occupies DEPTH−1 cycles after resetn deasserts; ready rises the following cycle.
- Latency from accept edge to done high: INSERT 3 cycles; REMOVE_NTH 2n+5 cycles; any error 1 cycle.
- ready low from the accept edge until the cycle after done.
- err is 0 whenever done is 0.
- Reset asserted mid-command or mid-INIT: immediate return to reset values, all lists discarded, INIT restarts on deassert; no partial done.
- list_sel ≥ NUM_LISTS on accept: error, 1-cycle done.
- Last free entry consumed: free_count 0, free_head NULL; next INSERT errors. Removing last card of a list: head NULL, count 0.

## Test plan

- ADDR_W=3: release reset → ready after 7 cycles, free_count 7, all counts 0.
- INSERT (value 5, suit 2), (9, 1), (12, 3) into list 1 → each done 3 cycles after accept, err 0, count 3, free_count 4.
- REMOVE_NTH n=1 on that list → done 7 cycles after accept, out = (9, 1), count 2; then n=0 → out = (12, 3) in 5 cycles; then n=0 → (5, 2).
- Fill all 7 entries across lists 0 and 2, eighth INSERT → err 1 at 1 cycle, free_count 0, no list changed; REMOVE then INSERT succeeds (free-list reuse).
- REMOVE_NTH n=3 on list of count 3, and on empty list → err 1, counts unchanged.
- Assert resetn mid REMOVE walk → outputs at reset values, re-INIT, all counts 0; start held during busy is ignored (exactly one done per accept).

Source files
------------

// File: rtl/card_list_manager.sv
// rtl/card_list_manager.sv - linked-list card store: per-list heads/counts, free-list allocator, single-port RAM
module card_list_manager #(
   parameter int ADDR_W    = 10,
   parameter int VALUE_W   = 4,
   parameter int SUIT_W    = 2,
   parameter int NUM_LISTS = 4,
   parameter int LIST_W    = 2
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic                op,
   input  logic [LIST_W-1:0]   list_sel,
   input  logic [VALUE_W-1:0]  in_value,
   input  logic [SUIT_W-1:0]   in_suit,
   input  logic [ADDR_W-1:0]   n,
   output logic                ready,
   output logic                done,
   output logic                err,
   output logic [VALUE_W-1:0]  out_value,
   output logic [SUIT_W-1:0]   out_suit,
   output logic [ADDR_W-1:0]   count,
   output logic [ADDR_W-1:0]   free_count
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int DW    = SUIT_W + VALUE_W;
   localparam int EW    = DW + ADDR_W;
   localparam logic [ADDR_W-1:0] NULL_PTR = '0;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   localparam logic [3:0] S_INIT     = 4'd0;
   localparam logic [3:0] S_IDLE     = 4'd1;
   localparam logic [3:0] S_INS_RD   = 4'd2;
   localparam logic [3:0] S_INS_WR   = 4'd3;
   localparam logic [3:0] S_REM_RD   = 4'd4;
   localparam logic [3:0] S_REM_CHK  = 4'd5;
   localparam logic [3:0] S_REM_LINK = 4'd6;
   localparam logic [3:0] S_REM_FREE = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   logic [EW-1:0]      mem [DEPTH];
   logic [EW-1:0]      ram_rd_q;
   logic [ADDR_W-1:0]  ram_addr;
   logic               ram_we;
   logic [EW-1:0]      ram_wdata;

   logic [3:0]         state_q, state_d;
   logic [ADDR_W-1:0]  init_addr_q, init_addr_d, init_next;
   logic [ADDR_W-1:0]  free_head_q, free_head_d;
   logic [ADDR_W-1:0]  free_count_q, free_count_d;
   logic [ADDR_W-1:0]  head_q [NUM_LISTS];
   logic [ADDR_W-1:0]  head_d [NUM_LISTS];
   logic [ADDR_W-1:0]  count_q [NUM_LISTS];
   logic [ADDR_W-1:0]  count_d [NUM_LISTS];
   logic               op_q, op_d;
   logic [LIST_W-1:0]  list_q, list_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [SUIT_W-1:0]  suit_q, suit_d;
   logic [ADDR_W-1:0]  n_q, n_d;
   logic [ADDR_W-1:0]  cur_q, cur_d;
   logic [ADDR_W-1:0]  prev_q, prev_d;
   logic [ADDR_W-1:0]  k_q, k_d;
   logic [DW-1:0]      prev_data_q, prev_data_d;
   logic [EW-1:0]      cur_entry_q, cur_entry_d;
   logic               err_q, err_d;
   logic [VALUE_W-1:0] out_value_q, out_value_d;
   logic [SUIT_W-1:0]  out_suit_q, out_suit_d;

   logic               sel_ok;
   logic [LIST_W-1:0]  sel_idx;
   logic [ADDR_W-1:0]  sel_count;

   always_comb begin
      sel_ok    = int'(list_sel) < NUM_LISTS;
      sel_idx   = sel_ok ? list_sel : '0;
      sel_count = sel_ok ? count_q[sel_idx] : '0;
   end

   // Natural wrap of the last address gives NULL as the tail's next pointer.
   assign init_next = init_addr_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      init_addr_d  = init_addr_q;
      free_head_d  = free_head_q;
      free_count_d = free_count_q;
      head_d       = head_q;
      count_d      = count_q;
      op_d         = op_q;
      list_d       = list_q;
      value_d      = value_q;
      suit_d       = suit_q;
      n_d          = n_q;
      cur_d        = cur_q;
      prev_d       = prev_q;
      k_d          = k_q;
      prev_data_d  = prev_data_q;
      cur_entry_d  = cur_entry_q;
      err_d        = err_q;
      out_value_d  = out_value_q;
      out_suit_d   = out_suit_q;
      ram_addr     = '0;
      ram_we       = 1'b0;
      ram_wdata    = '0;
      case (state_q)
         S_INIT: begin
            ram_addr    = init_addr_q;
            ram_we      = 1'b1;
            ram_wdata   = {{DW{1'b0}}, init_next};
            init_addr_d = init_next;
            if (init_addr_q == LAST_PTR) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               list_d  = list_sel;
               value_d = in_value;
               suit_d  = in_suit;
               n_d     = n;
               cur_d   = head_q[sel_idx];
               prev_d  = NULL_PTR;
               k_d     = '0;
               if (!sel_ok || (!op && free_count_q == '0) || (op && n >= sel_count)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = op ? S_REM_RD : S_INS_RD;
               end
            end
         end
         S_INS_RD: begin
            ram_addr = free_head_q;
            state_d  = S_INS_WR;
         end
         S_INS_WR: begin
            ram_addr        = free_head_q;
            ram_we          = 1'b1;
            ram_wdata       = {suit_q, value_q, head_q[list_q]};
            head_d[list_q]  = free_head_q;
            free_head_d     = ram_rd_q[ADDR_W-1:0];
            count_d[list_q] = count_q[list_q] + 1'b1;
            free_count_d    = free_count_q - 1'b1;
            state_d         = S_DONE;
         end
         S_REM_RD: begin
            ram_addr = cur_q;
            state_d  = S_REM_CHK;
         end
         S_REM_CHK: begin
            if (k_q < n_q) begin
               prev_d      = cur_q;
               prev_data_d = ram_rd_q[EW-1:ADDR_W];
               cur_d       = ram_rd_q[ADDR_W-1:0];
               k_d         = k_q + 1'b1;
               state_d     = S_REM_RD;
            end else begin
               cur_entry_d = ram_rd_q;
               state_d     = S_REM_LINK;
            end
         end
         S_REM_LINK: begin
            if (prev_q == NULL_PTR) begin
               head_d[list_q] = cur_entry_q[ADDR_W-1:0];
            end else begin
               ram_addr  = prev_q;
               ram_we    = 1'b1;
               ram_wdata = {prev_data_q, cur_entry_q[ADDR_W-1:0]};
            end
            state_d = S_REM_FREE;
         end
         S_REM_FREE: begin
            ram_addr        = cur_q;
            ram_we          = 1'b1;
            ram_wdata       = {cur_entry_q[EW-1:ADDR_W], free_head_q};
            free_head_d     = cur_q;
            count_d[list_q] = count_q[list_q] - 1'b1;
            free_count_d    = free_count_q + 1'b1;
            out_value_d     = cur_entry_q[ADDR_W +: VALUE_W];
            out_suit_d      = cur_entry_q[ADDR_W+VALUE_W +: SUIT_W];
            state_d         = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rd_q <= mem[ram_addr];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_INIT;
         init_addr_q  <= ADDR_W'(1);
         free_head_q  <= ADDR_W'(1);
         free_count_q <= LAST_PTR;
         for (int i = 0; i < NUM_LISTS; i++) begin
            head_q[i]  <= NULL_PTR;
            count_q[i] <= '0;
         end
         op_q        <= 1'b0;
         list_q      <= '0;
         value_q     <= '0;
         suit_q      <= '0;
         n_q         <= '0;
         cur_q       <= '0;
         prev_q      <= '0;
         k_q         <= '0;
         prev_data_q <= '0;
         cur_entry_q <= '0;
         err_q       <= 1'b0;
         out_value_q <= '0;
         out_suit_q  <= '0;
      end else begin
         state_q      <= state_d;
         init_addr_q  <= init_addr_d;
         free_head_q  <= free_head_d;
         free_count_q <= free_count_d;
         head_q       <= head_d;
         count_q      <= count_d;
         op_q         <= op_d;
         list_q       <= list_d;
         value_q      <= value_d;
         suit_q       <= suit_d;
         n_q          <= n_d;
         cur_q        <= cur_d;
         prev_q       <= prev_d;
         k_q          <= k_d;
         prev_data_q  <= prev_data_d;
         cur_entry_q  <= cur_entry_d;
         err_q        <= err_d;
         out_value_q  <= out_value_d;
         out_suit_q   <= out_suit_d;
      end
   end

   assign ready      = (state_q == S_IDLE);
   assign done       = (state_q == S_DONE);
   assign err        = done && err_q;
   assign out_value  = out_value_q;
   assign out_suit   = out_suit_q;
   assign count      = sel_count;
   assign free_count = free_count_q;
endmodule

// File: tb/tb_card_list_manager.sv
// tb/tb_card_list_manager.sv - randomized bench for card_list_manager against an array-based list model
module tb_card_list_manager;
   localparam int AW  = 3;
   localparam int VW  = 4;
   localparam int SW  = 2;
   localparam int NL  = 3;
   localparam int LW  = 2;
   localparam int CAP = 7;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          op = 1'b0;
   logic [LW-1:0] list_sel = '0;
   logic [VW-1:0] in_value = '0;
   logic [SW-1:0] in_suit = '0;
   logic [AW-1:0] n = '0;
   logic          ready, done, err;
   logic [VW-1:0] out_value;
   logic [SW-1:0] out_suit;
   logic [AW-1:0] count, free_count;

   int vectors = 0;
   int miscompares = 0;

   // model: each list is an array with index 0 as head
   logic [5:0]    ml [NL][CAP+1];
   int            mlen [NL];
   logic [VW-1:0] m_v;
   logic [SW-1:0] m_s;

   card_list_manager #(.ADDR_W(AW), .VALUE_W(VW), .SUIT_W(SW), .NUM_LISTS(NL), .LIST_W(LW)) dut (
      .clock(clock), .resetn(resetn), .start(start), .op(op), .list_sel(list_sel),
      .in_value(in_value), .in_suit(in_suit), .n(n), .ready(ready), .done(done), .err(err),
      .out_value(out_value), .out_suit(out_suit), .count(count), .free_count(free_count)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < NL; i++) mlen[i] = 0;
      m_v = '0;
      m_s = '0;
   endtask

   function automatic int model_count(int sel);
      return (sel < NL) ? mlen[sel] : 0;
   endfunction

   function automatic int model_free();
      int t = CAP;
      for (int i = 0; i < NL; i++) t -= mlen[i];
      return t;
   endfunction

   task automatic model_cmd(input bit o, input int sel, input int v, input int s, input int nn,
                            output bit xe, output int xl);
      xe = 1'b0;
      xl = 1;
      if (sel >= NL) xe = 1'b1;
      else if (!o) begin
         if (model_free() == 0) xe = 1'b1;
         else begin
            for (int i = mlen[sel]; i > 0; i--) ml[sel][i] = ml[sel][i-1];
            ml[sel][0] = {SW'(s), VW'(v)};
            mlen[sel]++;
            xl = 3;
         end
      end else begin
         if (nn >= mlen[sel]) xe = 1'b1;
         else begin
            {m_s, m_v} = ml[sel][nn];
            for (int i = nn; i < mlen[sel] - 1; i++) ml[sel][i] = ml[sel][i+1];
            mlen[sel]--;
            xl = 2 * nn + 5;
         end
      end
   endtask

   task automatic issue(input bit o, input int sel, input int v, input int s, input int nn, input bit hold,
                        output int lat, output bit e, output bit to, output bit rb);
      int w = 0;
      lat = 0; e = 1'b0; to = 1'b0; rb = 1'b0;
      while (ready !== 1'b1 && w < 100) begin @(negedge clock); w++; end
      if (ready !== 1'b1) begin to = 1'b1; return; end
      op = o; list_sel = LW'(sel); in_value = VW'(v); in_suit = SW'(s); n = AW'(nn);
      start = 1'b1;
      @(negedge clock);
      lat = 1;
      start = hold;
      while (done !== 1'b1 && lat < 100) begin
         if (ready === 1'b1) rb = 1'b1;
         if (hold) begin
            op = 1'($urandom); list_sel = LW'($urandom); in_value = VW'($urandom);
            in_suit = SW'($urandom); n = AW'($urandom);
         end
         @(negedge clock);
         lat++;
      end
      to = (done !== 1'b1);
      e = err;
      start = 1'b0;
      list_sel = LW'(sel);
      #1;
   endtask

   task automatic reset_dut(output int lat);
      @(negedge clock);
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      model_reset();
      lat = 0;
      while (ready !== 1'b1 && lat < 50) begin @(negedge clock); lat++; end
   endtask

   task automatic test_reset();
      int lat = 0;
      repeat (3) @(negedge clock);
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready); end
      vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
      vectors++; if ({out_suit, out_value} !== '0) begin miscompares++; $display("FAIL reset_out: got %0d/%0d expected 0/0", out_value, out_suit); end
      vectors++; if (free_count !== AW'(CAP)) begin miscompares++; $display("FAIL reset_free: got %0d expected %0d", free_count, CAP); end
      for (int q = 0; q < 4; q++) begin
         list_sel = LW'(q); #1;
         vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count%0d: got %0d expected 0", q, count); end
      end
      model_reset();
      @(negedge clock);
      resetn = 1'b1;
      while (ready !== 1'b1 && lat < 50) begin @(negedge clock); lat++; end
      vectors++; if (lat != CAP) begin miscompares++; $display("FAIL init_latency: got %0d expected %0d", lat, CAP); end
      vectors++; if (free_count !== AW'(CAP)) begin miscompares++; $display("FAIL init_free: got %0d expected %0d", free_count, CAP); end
   endtask

   task automatic test_insert_remove();
      int tab [6][5] = '{'{0,1,5,2,0}, '{0,1,9,1,0}, '{0,1,12,3,0}, '{1,1,0,0,1}, '{1,1,0,0,0}, '{1,1,0,0,0}};
      bit xe, e, to, rb;
      int xl, lat;
      foreach (tab[r]) begin
         model_cmd(tab[r][0] != 0, tab[r][1], tab[r][2], tab[r][3], tab[r][4], xe, xl);
         issue(tab[r][0] != 0, tab[r][1], tab[r][2], tab[r][3], tab[r][4], 1'b0, lat, e, to, rb);
         vectors++; if (to || lat != xl) begin miscompares++; $display("FAIL ins_rem_latency row %0d: got %0d expected %0d", r, lat, xl); end
         vectors++; if (e !== xe) begin miscompares++; $display("FAIL ins_rem_err row %0d: got %b expected %b", r, e, xe); end
         vectors++; if ({out_suit, out_value} !== {m_s, m_v}) begin miscompares++; $display("FAIL ins_rem_out row %0d: got %0d/%0d expected %0d/%0d", r, out_value, out_suit, m_v, m_s); end
         vectors++; if (free_count !== AW'(model_free())) begin miscompares++; $display("FAIL ins_rem_free row %0d: got %0d expected %0d", r, free_count, model_free()); end
         list_sel = LW'(1); #1;
         vectors++; if (count !== AW'(model_count(1))) begin miscompares++; $display("FAIL ins_rem_count row %0d: got %0d expected %0d", r, count, model_count(1)); end
      end
   endtask

   task automatic test_full_and_errors();
      int tab [15][5] = '{'{0,0,1,0,0}, '{0,0,2,1,0}, '{0,0,3,2,0}, '{0,0,4,3,0}, '{0,2,6,0,0},
                          '{0,2,7,1,0}, '{0,2,8,2,0}, '{0,1,15,3,0}, '{1,0,0,0,2}, '{0,1,11,1,0},
                          '{1,2,0,0,3}, '{1,1,0,0,0}, '{1,1,0,0,0}, '{0,3,13,2,0}, '{1,3,0,0,0}};
      bit xe, e, to, rb;
      int xl, lat;
      foreach (tab[r]) begin
         model_cmd(tab[r][0] != 0, tab[r][1], tab[r][2], tab[r][3], tab[r][4], xe, xl);
         issue(tab[r][0] != 0, tab[r][1], tab[r][2], tab[r][3], tab[r][4], 1'b0, lat, e, to, rb);
         vectors++; if (to || lat != xl) begin miscompares++; $display("FAIL full_latency row %0d: got %0d expected %0d", r, lat, xl); end
         vectors++; if (e !== xe) begin miscompares++; $display("FAIL full_err row %0d: got %b expected %b", r, e, xe); end
         vectors++; if ({out_suit, out_value} !== {m_s, m_v}) begin miscompares++; $display("FAIL full_out row %0d: got %0d/%0d expected %0d/%0d", r, out_value, out_suit, m_v, m_s); end
         vectors++; if (free_count !== AW'(model_free())) begin miscompares++; $display("FAIL full_free row %0d: got %0d expected %0d", r, free_count, model_free()); end
         for (int q = 0; q < 4; q++) begin
            list_sel = LW'(q); #1;
            vectors++; if (count !== AW'(model_count(q))) begin miscompares++; $display("FAIL full_count row %0d list %0d: got %0d expected %0d", r, q, count, model_count(q)); end
         end
      end
   endtask

   task automatic test_random();
      bit xe, e, to, rb, o;
      int xl, lat, sel, v, s, nn;
      for (int r = 0; r < 80; r++) begin
         o = ($urandom_range(0, 9) < 5);
         sel = $urandom_range(0, 3); v = $urandom_range(0, 15); s = $urandom_range(0, 3); nn = $urandom_range(0, 4);
         model_cmd(o, sel, v, s, nn, xe, xl);
         issue(o, sel, v, s, nn, 1'b0, lat, e, to, rb);
         vectors++; if (to || lat != xl) begin miscompares++; $display("FAIL rand_latency #%0d: got %0d expected %0d", r, lat, xl); end
         vectors++; if (e !== xe) begin miscompares++; $display("FAIL rand_err #%0d: got %b expected %b", r, e, xe); end
         vectors++; if ({out_suit, out_value} !== {m_s, m_v}) begin miscompares++; $display("FAIL rand_out #%0d: got %0d/%0d expected %0d/%0d", r, out_value, out_suit, m_v, m_s); end
         vectors++; if (free_count !== AW'(model_free())) begin miscompares++; $display("FAIL rand_free #%0d: got %0d expected %0d", r, free_count, model_free()); end
         for (int q = 0; q < 4; q++) begin
            list_sel = LW'(q); #1;
            vectors++; if (count !== AW'(model_count(q))) begin miscompares++; $display("FAIL rand_count #%0d list %0d: got %0d expected %0d", r, q, count, model_count(q)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit xe, e, to, rb, o;
      int xl, lat, sel, v, s, nn, extra;
      for (int r = 0; r < 12; r++) begin
         o = (r % 2 == 1);
         sel = $urandom_range(0, 2); v = $urandom_range(0, 15); s = $urandom_range(0, 3); nn = $urandom_range(0, 2);
         model_cmd(o, sel, v, s, nn, xe, xl);
         issue(o, sel, v, s, nn, 1'b1, lat, e, to, rb);
         vectors++; if (to || lat != xl) begin miscompares++; $display("FAIL b2b_latency #%0d: got %0d expected %0d", r, lat, xl); end
         vectors++; if (e !== xe) begin miscompares++; $display("FAIL b2b_err #%0d: got %b expected %b", r, e, xe); end
         vectors++; if (rb !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_busy #%0d: got %b expected 0", r, rb); end
         vectors++; if ({out_suit, out_value} !== {m_s, m_v}) begin miscompares++; $display("FAIL b2b_out #%0d: got %0d/%0d expected %0d/%0d", r, out_value, out_suit, m_v, m_s); end
         vectors++; if (count !== AW'(model_count(sel))) begin miscompares++; $display("FAIL b2b_count #%0d: got %0d expected %0d", r, count, model_count(sel)); end
         extra = 0;
         repeat (4) begin @(negedge clock); if (done === 1'b1) extra++; end
         vectors++; if (extra != 0) begin miscompares++; $display("FAIL b2b_extra_done #%0d: got %0d expected 0", r, extra); end
      end
      vectors++; if (free_count !== AW'(model_free())) begin miscompares++; $display("FAIL b2b_free: got %0d expected %0d", free_count, model_free()); end
   endtask

   task automatic test_reset_mid_walk();
      bit xe, e, to, rb;
      int xl, lat, seen;
      reset_dut(lat);
      for (int i = 0; i < 5; i++) begin
         model_cmd(1'b0, 0, 10 + i, i % 4, 0, xe, xl);
         issue(1'b0, 0, 10 + i, i % 4, 0, 1'b0, lat, e, to, rb);
      end
      model_cmd(1'b1, 0, 0, 0, 0, xe, xl);
      issue(1'b1, 0, 0, 0, 0, 1'b0, lat, e, to, rb);
      vectors++; if (to || {out_suit, out_value} !== {m_s, m_v}) begin miscompares++; $display("FAIL walk_pre_out: got %0d/%0d expected %0d/%0d", out_value, out_suit, m_v, m_s); end
      seen = 0;
      while (ready !== 1'b1 && seen < 100) begin @(negedge clock); seen++; end
      op = 1'b1; list_sel = '0; n = AW'(3); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      seen = 0;
      repeat (5) begin @(negedge clock); if (done === 1'b1) seen++; end
      resetn = 1'b0;
      #1;
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL walk_early_done: got %0d expected 0", seen); end
      vectors++; if (ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL walk_reset_flags: got %b%b%b expected 000", ready, done, err); end
      vectors++; if ({out_suit, out_value} !== '0) begin miscompares++; $display("FAIL walk_reset_out: got %0d/%0d expected 0/0", out_value, out_suit); end
      vectors++; if (free_count !== AW'(CAP)) begin miscompares++; $display("FAIL walk_reset_free: got %0d expected %0d", free_count, CAP); end
      @(negedge clock);
      resetn = 1'b1;
      model_reset();
      lat = 0; seen = 0;
      while (ready !== 1'b1 && lat < 50) begin @(negedge clock); lat++; if (done === 1'b1) seen++; end
      vectors++; if (lat != CAP || seen != 0) begin miscompares++; $display("FAIL walk_reinit: got latency %0d dones %0d expected %0d and 0", lat, seen, CAP); end
      for (int q = 0; q < 4; q++) begin
         list_sel = LW'(q); #1;
         vectors++; if (count !== '0) begin miscompares++; $display("FAIL walk_count%0d: got %0d expected 0", q, count); end
      end
      model_cmd(1'b0, 2, 7, 3, 0, xe, xl);
      issue(1'b0, 2, 7, 3, 0, 1'b0, lat, e, to, rb);
      model_cmd(1'b1, 2, 0, 0, 0, xe, xl);
      issue(1'b1, 2, 0, 0, 0, 1'b0, lat, e, to, rb);
      vectors++; if (to || lat != xl || e !== xe || {out_suit, out_value} !== {m_s, m_v}) begin
         miscompares++; $display("FAIL walk_after: got lat %0d err %b out %0d/%0d expected lat %0d err %b out %0d/%0d", lat, e, out_value, out_suit, xl, xe, m_v, m_s);
      end
   endtask

   initial begin
      test_reset();
      test_insert_remove();
      test_full_and_errors();
      test_random();
      test_back_to_back();
      test_reset_mid_walk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
